// File: rtl/rv32i_fetch_unit.sv
// Instruction fetch stage: PC, credit-limited imem requests, prefetch FIFO to decode, redirect flush.
// Optional macro FETCH_BYPASS_EN forwards a response straight to decode when nothing is buffered.
module rv32i_fetch_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [WIDTH-1:0] id_instr,
  output logic [WIDTH-1:0] id_pc,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] pc;
  logic [CW-1:0]    outstanding, drop, count;
  logic [CW-1:0]    outstanding_next, count_next;
  logic [AW-1:0]    wptr, rptr, tag_wptr, tag_rptr;
  logic [WIDTH-1:0] instr_mem [DEPTH];
  logic [WIDTH-1:0] pc_mem    [DEPTH];
  logic [WIDTH-1:0] tag_mem   [DEPTH];

  logic [CW:0]      inflight;
  logic             req_fire, rsp_keep, head_valid, push, pop;
  logic [WIDTH-1:0] rsp_pc;
  logic             unused_low_bits;

  assign unused_low_bits = ^redirect_pc[1:0];

  // Credit covers both in-flight requests and buffered words, so a response always has a slot.
  assign inflight       = {1'b0, outstanding} + {1'b0, count};
  assign imem_req_valid = rst && (inflight < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_pc     = tag_mem[tag_rptr];
  assign rsp_keep   = imem_rsp_valid && !redirect_valid && (drop == '0);
  assign head_valid = (count != '0);
  assign pop        = head_valid && id_ready;

`ifdef FETCH_BYPASS_EN
  logic bypass_sel;
  assign bypass_sel = !head_valid && rsp_keep;
  assign push       = rsp_keep && !(bypass_sel && id_ready);

  always_comb begin
    id_valid = head_valid || bypass_sel;
    id_instr = '0;
    id_pc    = '0;
    if (head_valid) begin
      id_instr = instr_mem[rptr];
      id_pc    = pc_mem[rptr];
    end else if (bypass_sel) begin
      id_instr = imem_rsp_data;
      id_pc    = rsp_pc;
    end
  end
`else
  assign push = rsp_keep;

  always_comb begin
    id_valid = head_valid;
    id_instr = '0;
    id_pc    = '0;
    if (head_valid) begin
      id_instr = instr_mem[rptr];
      id_pc    = pc_mem[rptr];
    end
  end
`endif

  always_comb begin
    outstanding_next = outstanding;
    case ({req_fire, imem_rsp_valid})
      2'b10:   outstanding_next = outstanding + CW'(1);
      2'b01:   outstanding_next = outstanding - CW'(1);
      default: outstanding_next = outstanding;
    endcase
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Storage arrays carry no reset; their contents are only observed behind the pointers.
  always_ff @(posedge clk) begin
    if (req_fire) tag_mem[tag_wptr] <= pc;
    if (push && !redirect_valid) begin
      instr_mem[wptr] <= imem_rsp_data;
      pc_mem[wptr]    <= rsp_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      count       <= '0;
      wptr        <= '0;
      rptr        <= '0;
      tag_wptr    <= '0;
      tag_rptr    <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (req_fire)       tag_wptr <= tag_wptr + AW'(1);
      if (imem_rsp_valid) tag_rptr <= tag_rptr + AW'(1);
      if (redirect_valid) begin
        // Everything still in flight after this cycle belongs to the old path.
        pc    <= {redirect_pc[WIDTH-1:2], 2'b00};
        drop  <= outstanding_next;
        count <= '0;
        rptr  <= wptr;
      end else begin
        if (req_fire) pc <= pc + WIDTH'(4);
        if (push) wptr <= wptr + AW'(1);
        if (pop)  rptr <= rptr + AW'(1);
        count <= count_next;
        if (imem_rsp_valid && (drop != '0)) drop <= drop - CW'(1);
      end
    end
  end
endmodule
